// File: rtl/core_sram_controller_if.sv
// Request/response bundle between the core, the management bus and the 1RW SRAM macro.
// The controller uses the slave view; requesters and the macro model use master.
interface core_sram_controller_if #(
  parameter int SRAM_ADDRESS_SIZE = 8
);
  logic [31:0]                  core_address;
  logic [3:0]                   core_byteSelect;
  logic                         core_writeEnable;
  logic                         core_readEnable;
  logic [31:0]                  core_dataWrite;
  logic [31:0]                  core_dataRead;
  logic                         core_busy;
  logic                         core_addressError;

  logic                         management_enable;
  logic                         management_writeEnable;
  logic [3:0]                   management_byteSelect;
  logic [31:0]                  management_address;
  logic [31:0]                  management_writeData;
  logic [31:0]                  management_readData;
  logic                         management_ack;

  logic                         sram_csb;
  logic                         sram_web;
  logic [3:0]                   sram_wmask;
  logic [SRAM_ADDRESS_SIZE-1:0] sram_addr;
  logic [31:0]                  sram_din;
  logic [31:0]                  sram_dout;

  modport slave (
    input  core_address, core_byteSelect, core_writeEnable, core_readEnable, core_dataWrite,
    output core_dataRead, core_busy, core_addressError,
    input  management_enable, management_writeEnable, management_byteSelect,
    input  management_address, management_writeData,
    output management_readData, management_ack,
    output sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    input  sram_dout
  );

  modport master (
    output core_address, core_byteSelect, core_writeEnable, core_readEnable, core_dataWrite,
    input  core_dataRead, core_busy, core_addressError,
    output management_enable, management_writeEnable, management_byteSelect,
    output management_address, management_writeData,
    input  management_readData, management_ack,
    input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/core_sram_controller.sv
// Two-cycle arbiter (issue, complete) from core and management ports onto one 1RW SRAM.
// Management wins ties; out-of-range addresses complete with an error and never touch the macro.
module core_sram_controller #(
  parameter int SRAM_ADDRESS_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  core_sram_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CORE_DONE, MGMT_DONE} state_t;

  state_t     state_q, state_d;
  logic       err_q, err_d;
  logic       wr_q, wr_d;
  logic [3:0] mask_q, mask_d;

  logic        core_req;
  logic        sel_mgmt;
  logic [31:0] sel_addr;
  logic [3:0]  sel_bs;
  logic        sel_we;
  logic [31:0] sel_wd;
  logic        in_range;
  logic        unused_addr_bits;

  function automatic logic [31:0] lanes(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  // Word-aligned addresses: the low two bits carry no information.
  assign unused_addr_bits = ^{bus.core_address[1:0], bus.management_address[1:0]};

  assign core_req = (bus.core_readEnable | bus.core_writeEnable) && (bus.core_byteSelect != 4'b0000);
  assign sel_mgmt = bus.management_enable;
  assign sel_addr = sel_mgmt ? bus.management_address     : bus.core_address;
  assign sel_bs   = sel_mgmt ? bus.management_byteSelect  : bus.core_byteSelect;
  assign sel_we   = sel_mgmt ? bus.management_writeEnable : bus.core_writeEnable;
  assign sel_wd   = sel_mgmt ? bus.management_writeData   : bus.core_dataWrite;
  assign in_range = (sel_addr[31:SRAM_ADDRESS_SIZE+2] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    err_d                   = err_q;
    wr_d                    = wr_q;
    mask_d                  = mask_q;
    bus.sram_csb            = 1'b1;
    bus.sram_web            = 1'b1;
    bus.sram_wmask          = 4'b0000;
    bus.sram_addr           = '0;
    bus.sram_din            = 32'h0;
    bus.core_busy           = 1'b0;
    bus.core_addressError   = 1'b0;
    bus.core_dataRead       = 32'h0;
    bus.management_ack      = 1'b0;
    bus.management_readData = 32'h0;

    // Outputs are gated by rst so a reset landing in a DONE state suppresses the pulse.
    case (state_q)
      IDLE: begin
        if (!rst && (sel_mgmt || core_req)) begin
          state_d = sel_mgmt ? MGMT_DONE : CORE_DONE;
          err_d   = !in_range;
          wr_d    = sel_we;
          mask_d  = sel_bs;
          if (in_range) begin
            bus.sram_csb   = 1'b0;
            bus.sram_web   = !sel_we;
            bus.sram_wmask = sel_we ? sel_bs : 4'b0000;
            bus.sram_addr  = sel_addr[SRAM_ADDRESS_SIZE+1:2];
            bus.sram_din   = sel_wd;
          end
        end
      end
      CORE_DONE: begin
        state_d = IDLE;
        if (!rst) begin
          bus.core_busy         = 1'b1;
          bus.core_addressError = err_q;
          if (!err_q && !wr_q) bus.core_dataRead = bus.sram_dout & lanes(mask_q);
        end
      end
      MGMT_DONE: begin
        state_d = IDLE;
        if (!rst) begin
          bus.management_ack = 1'b1;
          if (!wr_q) bus.management_readData = err_q ? 32'hFFFF_FFFF : (bus.sram_dout & lanes(mask_q));
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_sram_controller.sv
// Directed bench for core_sram_controller: SRAM behavioural model, per-port scoreboards
// checked by a monitor on every completion pulse, plus issue-cycle SRAM pin checks.
module tb_core_sram_controller;

  localparam int AW = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;

  core_sram_controller_if #(.SRAM_ADDRESS_SIZE(AW)) if_i ();

  core_sram_controller #(.SRAM_ADDRESS_SIZE(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (if_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1RW macro model: read data appears the cycle after the issue edge.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!if_i.sram_csb) begin
      if (!if_i.sram_web) begin
        for (int i = 0; i < 4; i++)
          if (if_i.sram_wmask[i]) mem[if_i.sram_addr][8*i +: 8] <= if_i.sram_din[8*i +: 8];
      end else begin
        if_i.sram_dout <= mem[if_i.sram_addr];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t core_q[$];
  exp_t mgmt_q[$];

  logic        iss_csb, iss_web;
  logic [3:0]  iss_wmask;
  logic [7:0]  iss_addr;
  logic [31:0] iss_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the head of its port's scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_i.core_busy === 1'b1) begin
          if (core_q.size() == 0) check("core_unexpected_pulse", 32'd1, 32'd0);
          else begin
            e = core_q.pop_front();
            check("core_dataRead", if_i.core_dataRead, e.data);
            check("core_addressError", {31'd0, if_i.core_addressError}, {31'd0, e.err});
            check("core_pulse_cycle", cyc, e.cyc);
          end
        end
        if (if_i.management_ack === 1'b1) begin
          if (mgmt_q.size() == 0) check("mgmt_unexpected_ack", 32'd1, 32'd0);
          else begin
            e = mgmt_q.pop_front();
            check("mgmt_readData", if_i.management_readData, e.data);
            check("mgmt_ack_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic capture_issue();
    iss_csb   = if_i.sram_csb;
    iss_web   = if_i.sram_web;
    iss_wmask = if_i.sram_wmask;
    iss_addr  = if_i.sram_addr;
    iss_din   = if_i.sram_din;
  endtask

  // Called at posedge+1; leaves the request asserted until the posedge after the pulse.
  task automatic core_access(input logic [31:0] addr, input logic [3:0] bs, input logic we,
                             input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    bit   seen;
    if_i.core_address     = addr;
    if_i.core_byteSelect  = bs;
    if_i.core_writeEnable = we;
    if_i.core_readEnable  = !we;
    if_i.core_dataWrite   = wd;
    e.cyc = cyc + 1; e.data = exp_d; e.err = exp_e;
    core_q.push_back(e);
    @(negedge clk);
    capture_issue();
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (if_i.core_busy) seen = 1;
    end
    if (!seen) check("core_pulse_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_i.core_writeEnable = 1'b0;
    if_i.core_readEnable  = 1'b0;
  endtask

  task automatic mgmt_access(input logic [31:0] addr, input logic [3:0] bs, input logic we,
                             input logic [31:0] wd, input logic [31:0] exp_d);
    exp_t e;
    bit   seen;
    if_i.management_address     = addr;
    if_i.management_byteSelect  = bs;
    if_i.management_writeEnable = we;
    if_i.management_writeData   = wd;
    if_i.management_enable      = 1'b1;
    e.cyc = cyc + 1; e.data = exp_d; e.err = 1'b0;
    mgmt_q.push_back(e);
    @(negedge clk);
    capture_issue();
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (if_i.management_ack) seen = 1;
    end
    if (!seen) check("mgmt_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_i.management_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    bit   seen;
    cyc = 0; n_chk = 0; n_fail = 0;
    rst = 1'b1;
    if_i.core_address = 32'h10; if_i.core_byteSelect = 4'hF;
    if_i.core_writeEnable = 1'b0; if_i.core_readEnable = 1'b1; if_i.core_dataWrite = 32'h0;
    if_i.management_enable = 1'b1; if_i.management_writeEnable = 1'b1;
    if_i.management_byteSelect = 4'hF; if_i.management_address = 32'h0;
    if_i.management_writeData = 32'h0;

    // Requests held during reset must not issue.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_csb", {31'd0, if_i.sram_csb}, 32'd1);
    check("rst_web", {31'd0, if_i.sram_web}, 32'd1);
    check("rst_wmask", {28'd0, if_i.sram_wmask}, 32'd0);
    check("rst_addr", {24'd0, if_i.sram_addr}, 32'd0);
    check("rst_busy", {31'd0, if_i.core_busy}, 32'd0);
    check("rst_ack", {31'd0, if_i.management_ack}, 32'd0);
    check("rst_core_data", if_i.core_dataRead, 32'd0);
    check("rst_mgmt_data", if_i.management_readData, 32'd0);
    if_i.core_readEnable = 1'b0;
    if_i.management_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Full write then readback.
    core_access(32'h10, 4'hF, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    check("wr_issue_csb", {31'd0, iss_csb}, 32'd0);
    check("wr_issue_web", {31'd0, iss_web}, 32'd0);
    check("wr_issue_addr", {24'd0, iss_addr}, 32'd4);
    check("wr_issue_wmask", {28'd0, iss_wmask}, 32'hF);
    check("wr_issue_din", iss_din, 32'hDEADBEEF);
    core_access(32'h10, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    check("rd_issue_web", {31'd0, iss_web}, 32'd1);
    check("rd_issue_wmask", {28'd0, iss_wmask}, 32'd0);

    // Byte-lane write preserves other lanes; lane-masked read.
    core_access(32'h20, 4'hF, 1'b1, 32'h11223344, 32'h0, 1'b0);
    core_access(32'h20, 4'b0010, 1'b1, 32'h0000AA00, 32'h0, 1'b0);
    check("bytewr_wmask", {28'd0, iss_wmask}, 32'h2);
    core_access(32'h20, 4'hF, 1'b0, 32'h0, 32'h1122AA44, 1'b0);
    core_access(32'h20, 4'b0100, 1'b0, 32'h0, 32'h00220000, 1'b0);

    // Out-of-range accesses: no SRAM activity, error pulse, address 0 not aliased.
    core_access(32'h0, 4'hF, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);
    core_access(32'h400, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1);
    check("oor_rd_csb", {31'd0, iss_csb}, 32'd1);
    core_access(32'h400, 4'hF, 1'b1, 32'h12345678, 32'h0, 1'b1);
    check("oor_wr_csb", {31'd0, iss_csb}, 32'd1);
    core_access(32'h0, 4'hF, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);

    // Management accesses.
    mgmt_access(32'h30, 4'hF, 1'b1, 32'h55667788, 32'h0);
    check("mgmt_wr_addr", {24'd0, iss_addr}, 32'd12);
    mgmt_access(32'h30, 4'b0001, 1'b0, 32'h0, 32'h00000088);
    mgmt_access(32'h800, 4'hF, 1'b0, 32'h0, 32'hFFFFFFFF);
    check("mgmt_oor_csb", {31'd0, iss_csb}, 32'd1);
    mgmt_access(32'h800, 4'hF, 1'b1, 32'h1, 32'h0);

    // Simultaneous requests: management at +1, core at +3.
    if_i.management_address = 32'h30; if_i.management_byteSelect = 4'hF;
    if_i.management_writeEnable = 1'b0; if_i.management_enable = 1'b1;
    if_i.core_address = 32'h10; if_i.core_byteSelect = 4'hF;
    if_i.core_writeEnable = 1'b0; if_i.core_readEnable = 1'b1;
    e.cyc = cyc + 1; e.data = 32'h55667788; e.err = 1'b0; mgmt_q.push_back(e);
    e.cyc = cyc + 3; e.data = 32'hDEADBEEF; e.err = 1'b0; core_q.push_back(e);
    @(negedge clk);
    check("sim_issue_addr_mgmt", {24'd0, if_i.sram_addr}, 32'd12);
    @(posedge clk); @(posedge clk); #1;
    if_i.management_enable = 1'b0;
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (if_i.core_busy) seen = 1;
    end
    if (!seen) check("sim_core_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_i.core_readEnable = 1'b0;

    // Back-to-back fetch then load: pulses at +1 and +3.
    core_access(32'h10, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    core_access(32'h20, 4'hF, 1'b0, 32'h0, 32'h1122AA44, 1'b0);

    // byteSelect 0 is ignored.
    if_i.core_address = 32'h10; if_i.core_byteSelect = 4'h0; if_i.core_readEnable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("bs0_csb", {31'd0, if_i.sram_csb}, 32'd1);
    end
    @(posedge clk); #1;
    if_i.core_readEnable = 1'b0;

    // Reset in CORE_DONE aborts the pulse; a following read completes normally.
    if_i.core_address = 32'h20; if_i.core_byteSelect = 4'hF; if_i.core_readEnable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    if_i.core_readEnable = 1'b0;
    @(negedge clk);
    check("rst_done_busy", {31'd0, if_i.core_busy}, 32'd0);
    check("rst_done_data", if_i.core_dataRead, 32'd0);
    check("rst_done_csb", {31'd0, if_i.sram_csb}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    core_access(32'h20, 4'hF, 1'b0, 32'h0, 32'h1122AA44, 1'b0);
    check("post_rst_issue_csb", {31'd0, iss_csb}, 32'd0);

    repeat (3) @(posedge clk);
    check("core_q_drained", core_q.size(), 32'd0);
    check("mgmt_q_drained", mgmt_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
